pipeline_stage0: RTL and testbench

Instruction fetch stage; sits directly upstream of pipeline stage 1 and drives its PipeIn byte.
- Owns the program counter and issues one opcode-byte read per cycle to the memory bus.
- Registers the fetched byte, and the PC it came from, for stage 1.
- Injects NOP bubbles on reset flush, branch load, bus hand-over and stage-1 fetch suppression.

---
 rtl/pipeline_stage0.sv | 75 +++++++
 tb/tb_pipeline_stage0.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage0.sv
// Instruction fetch stage: owns the PC, fetches one opcode byte per cycle and
// hands it, with its address, to stage 1; injects NOP bubbles when not fetching.
module pipeline_stage0 #(
  parameter int unsigned             PC_WIDTH     = 16,
  parameter logic [7:0]              NOP_OPCODE   = 8'h00,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned             FLUSH_CYCLES = 3
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                BusRequest,
  output logic                BusGrant,
  input  logic                FetchSurpress,
  input  logic                PCLoad,
  input  logic [PC_WIDTH-1:0] PCLoadValue,
  output logic [PC_WIDTH-1:0] MemAddr,
  output logic                MemRead,
  input  logic [7:0]          MemData,
  output logic [7:0]          PipeOut,
  output logic [PC_WIDTH-1:0] PipePC,
  output logic                FlushActive,
  output logic                debug_state
);

  localparam logic       FLUSH = 1'b0;
  localparam logic       FETCH = 1'b1;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic                state;
  logic [3:0]          flush_cnt;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          pipe_out;
  logic [PC_WIDTH-1:0] pipe_pc;
  logic                in_fetch;

  // Reset overrides the bus-facing strobes even though the state is registered.
  assign in_fetch    = (state == FETCH) && !Reset;
  assign MemAddr     = pc;
  assign MemRead     = in_fetch && !PCLoad && !BusRequest && !FetchSurpress;
  assign BusGrant    = in_fetch && BusRequest && !FetchSurpress;
  assign FlushActive = Reset || (state == FLUSH);
  assign PipeOut     = pipe_out;
  assign PipePC      = pipe_pc;
  assign debug_state = state;

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state     <= FLUSH;
      flush_cnt <= FLUSH_INIT;
      pc        <= RESET_VECTOR;
      pipe_out  <= NOP_OPCODE;
      pipe_pc   <= RESET_VECTOR;
    end else if (state == FLUSH) begin
      pipe_out  <= NOP_OPCODE;
      flush_cnt <= flush_cnt - 4'd1;
      if (flush_cnt == 4'd1) begin
        state <= FETCH;
      end
    end else if (PCLoad) begin
      // Branch squashes this cycle's slot; the target is fetched next cycle.
      pc       <= PCLoadValue;
      pipe_out <= NOP_OPCODE;
      pipe_pc  <= pc;
    end else if (BusRequest || FetchSurpress) begin
      pipe_out <= NOP_OPCODE;
      pipe_pc  <= pc;
    end else begin
      pipe_out <= MemData;
      pipe_pc  <= pc;
      pc       <= pc + PC_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_stage0.sv
// Directed bench for the fetch stage: a combinational byte memory model feeds
// MemData and each scenario task checks hand-computed outputs.
module tb_pipeline_stage0;

  logic        clk;
  logic        reset;
  logic        bus_request;
  logic        bus_grant;
  logic        fetch_surpress;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_data;
  logic [7:0]  pipe_out;
  logic [15:0] pipe_pc;
  logic        flush_active;
  logic        debug_state;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          passed = 0;

  assign mem_data = mem[mem_addr];

  pipeline_stage0 dut (
    .ClockIn      (clk),
    .Reset        (reset),
    .BusRequest   (bus_request),
    .BusGrant     (bus_grant),
    .FetchSurpress(fetch_surpress),
    .PCLoad       (pc_load),
    .PCLoadValue  (pc_load_value),
    .MemAddr      (mem_addr),
    .MemRead      (mem_read),
    .MemData      (mem_data),
    .PipeOut      (pipe_out),
    .PipePC       (pipe_pc),
    .FlushActive  (flush_active),
    .debug_state  (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_request = 1'b0; fetch_surpress = 1'b0;
    pc_load = 1'b0; pc_load_value = 16'h0000;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    step(); step();
    checks++; if (pipe_out !== 8'h00) $display("FAIL reset_pipe_out got %h exp 00", pipe_out); else passed++;
    checks++; if (pipe_pc !== 16'h0000) $display("FAIL reset_pipe_pc got %h exp 0000", pipe_pc); else passed++;
    checks++; if (flush_active !== 1'b1) $display("FAIL reset_flush_active got %b exp 1", flush_active); else passed++;
    checks++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read got %b exp 0", mem_read); else passed++;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (flush_active !== 1'b1) $display("FAIL flush_active_%0d got %b exp 1", i, flush_active); else passed++;
      checks++; if (mem_read !== 1'b0) $display("FAIL flush_mem_read_%0d got %b exp 0", i, mem_read); else passed++;
      step();
      checks++; if (pipe_out !== 8'h00) $display("FAIL flush_pipe_out_%0d got %h exp 00", i, pipe_out); else passed++;
    end
    checks++; if (flush_active !== 1'b0) $display("FAIL flush_end got %b exp 0", flush_active); else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      exp_b = 8'h11 * (i + 1);
      checks++; if (mem_read !== 1'b1) $display("FAIL fetch_mem_read_%0d got %b exp 1", i, mem_read); else passed++;
      step();
      checks++; if (pipe_out !== exp_b) $display("FAIL fetch_pipe_out_%0d got %h exp %h", i, pipe_out, exp_b); else passed++;
      checks++; if (pipe_pc !== 16'(i)) $display("FAIL fetch_pipe_pc_%0d got %h exp %h", i, pipe_pc, 16'(i)); else passed++;
    end
  endtask

  task automatic test_branch();
    mem[4] = 8'h5E; mem[16'h0100] = 8'hA5;
    step();
    checks++; if (mem_addr !== 16'h0005) $display("FAIL branch_pc got %h exp 0005", mem_addr); else passed++;
    pc_load = 1'b1; pc_load_value = 16'h0100;
    #1;
    checks++; if (mem_read !== 1'b0) $display("FAIL branch_mem_read got %b exp 0", mem_read); else passed++;
    step();
    pc_load = 1'b0;
    checks++; if (pipe_out !== 8'h00) $display("FAIL branch_squash got %h exp 00", pipe_out); else passed++;
    step();
    checks++; if (pipe_out !== 8'hA5) $display("FAIL branch_target got %h exp a5", pipe_out); else passed++;
    checks++; if (pipe_pc !== 16'h0100) $display("FAIL branch_pipe_pc got %h exp 0100", pipe_pc); else passed++;
  endtask

  task automatic test_bus_handover();
    mem[16'h0010] = 8'h77;
    pc_load = 1'b1; pc_load_value = 16'h0010;
    step();
    pc_load = 1'b0; bus_request = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_grant !== 1'b1) $display("FAIL bus_grant_%0d got %b exp 1", i, bus_grant); else passed++;
      checks++; if (mem_read !== 1'b0) $display("FAIL bus_mem_read_%0d got %b exp 0", i, mem_read); else passed++;
      checks++; if (mem_addr !== 16'h0010) $display("FAIL bus_pc_%0d got %h exp 0010", i, mem_addr); else passed++;
      step();
      checks++; if (pipe_out !== 8'h00) $display("FAIL bus_pipe_out_%0d got %h exp 00", i, pipe_out); else passed++;
    end
    bus_request = 1'b0;
    #1;
    checks++; if (bus_grant !== 1'b0) $display("FAIL bus_release got %b exp 0", bus_grant); else passed++;
    step();
    checks++; if (pipe_out !== 8'h77) $display("FAIL bus_resume got %h exp 77", pipe_out); else passed++;
    checks++; if (pipe_pc !== 16'h0010) $display("FAIL bus_resume_pc got %h exp 0010", pipe_pc); else passed++;
  endtask

  task automatic test_suppress_vs_request();
    fetch_surpress = 1'b1; bus_request = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus_grant !== 1'b0) $display("FAIL sup_grant_%0d got %b exp 0", i, bus_grant); else passed++;
      checks++; if (mem_read !== 1'b0) $display("FAIL sup_mem_read_%0d got %b exp 0", i, mem_read); else passed++;
      step();
      checks++; if (pipe_out !== 8'h00) $display("FAIL sup_pipe_out_%0d got %h exp 00", i, pipe_out); else passed++;
      checks++; if (mem_addr !== 16'h0011) $display("FAIL sup_pc_%0d got %h exp 0011", i, mem_addr); else passed++;
    end
    fetch_surpress = 1'b0;
    #1;
    checks++; if (bus_grant !== 1'b1) $display("FAIL sup_then_grant got %b exp 1", bus_grant); else passed++;
    step();
    bus_request = 1'b0;
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    pc_load = 1'b1; pc_load_value = 16'hFFFF;
    step();
    pc_load = 1'b0;
    step();
    checks++; if (pipe_out !== 8'h5A) $display("FAIL wrap_top got %h exp 5a", pipe_out); else passed++;
    checks++; if (pipe_pc !== 16'hFFFF) $display("FAIL wrap_top_pc got %h exp ffff", pipe_pc); else passed++;
    step();
    checks++; if (pipe_out !== 8'hC3) $display("FAIL wrap_zero got %h exp c3", pipe_out); else passed++;
    checks++; if (pipe_pc !== 16'h0000) $display("FAIL wrap_zero_pc got %h exp 0000", pipe_pc); else passed++;
  endtask

  task automatic test_reset_mid();
    mem[16'h1234] = 8'h99;
    bus_request = 1'b1; pc_load = 1'b1; pc_load_value = 16'h1234; reset = 1'b1;
    #1;
    checks++; if (bus_grant !== 1'b0) $display("FAIL mid_grant got %b exp 0", bus_grant); else passed++;
    checks++; if (mem_read !== 1'b0) $display("FAIL mid_mem_read got %b exp 0", mem_read); else passed++;
    step();
    reset = 1'b0;
    checks++; if (mem_addr !== 16'h0000) $display("FAIL mid_pc got %h exp 0000", mem_addr); else passed++;
    checks++; if (pipe_out !== 8'h00) $display("FAIL mid_pipe_out got %h exp 00", pipe_out); else passed++;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (flush_active !== 1'b1) $display("FAIL mid_flush_%0d got %b exp 1", i, flush_active); else passed++;
      checks++; if (bus_grant !== 1'b0) $display("FAIL mid_flush_grant_%0d got %b exp 0", i, bus_grant); else passed++;
      step();
      checks++; if (mem_addr !== 16'h0000) $display("FAIL mid_flush_pc_%0d got %h exp 0000", i, mem_addr); else passed++;
    end
    checks++; if (flush_active !== 1'b0) $display("FAIL mid_flush_end got %b exp 0", flush_active); else passed++;
    bus_request = 1'b0; pc_load = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1) $display("FAIL mid_resume_read got %b exp 1", mem_read); else passed++;
    step();
    checks++; if (pipe_out !== 8'hC3) $display("FAIL mid_resume got %h exp c3", pipe_out); else passed++;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_branch();
    test_bus_handover();
    test_suppress_vs_request();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
